// File: rtl/instr_fetch_issue_if.sv
// ============================================================================
// Module   : instr_fetch_issue_if
// Function : Control, memory-read and instruction-issue signals of the fetch unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface instr_fetch_issue_if #(
    parameter int AW = 12,
    parameter int DW = 16
);
    logic          start;
    logic          pc_load;
    logic [AW-1:0] pc_in;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    logic [AW-1:0] IR_address;
    logic [2:0]    opcode;
    logic          I;
    logic          instr_valid;
    logic          instr_ack;
    logic          halted;
    logic [15:0]   fetch_count;

    modport master (
        input  start, pc_load, pc_in, mem_rdata, mem_ready, instr_ack,
        output mem_addr, mem_rd, IR_address, opcode, I, instr_valid, halted, fetch_count
    );

    modport slave (
        output start, pc_load, pc_in, mem_rdata, mem_ready, instr_ack,
        input  mem_addr, mem_rd, IR_address, opcode, I, instr_valid, halted, fetch_count
    );
endinterface

`default_nettype wire

// File: rtl/instr_fetch_issue.sv
// ============================================================================
// Module   : instr_fetch_issue
// Function : PC/IR fetch sequencer issuing I/opcode/address fields to the CPU;
//            define HLT_DETECT_EN to stop on the HLT word 16'h7001.
// Revision : 1.0
// ============================================================================
`default_nettype none

module instr_fetch_issue #(
    parameter int AW = 12,
    parameter int DW = 16
) (
    input  logic               clk,
    input  logic               reset,
    instr_fetch_issue_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2,
        S_HALT  = 2'd3
    } state_t;

`ifdef HLT_DETECT_EN
    localparam logic [DW-1:0] c_HLT_WORD = 16'h7001;
    logic r_halted;
`endif

    state_t        r_state;
    logic [AW-1:0] r_pc;
    logic [DW-1:0] r_ir;
    logic [15:0]   r_fetch_count;
    logic          r_mem_rd;
    logic          r_instr_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_pc          <= '0;
            r_ir          <= '0;
            r_fetch_count <= '0;
            r_mem_rd      <= 1'b0;
            r_instr_valid <= 1'b0;
`ifdef HLT_DETECT_EN
            r_halted      <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    // A simultaneous load and start fetches from the loaded PC.
                    if (bus.pc_load) begin
                        r_pc <= bus.pc_in;
                    end
                    if (bus.start) begin
                        r_state  <= S_FETCH;
                        r_mem_rd <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (bus.mem_ready) begin
                        r_ir     <= bus.mem_rdata;
                        r_mem_rd <= 1'b0;
`ifdef HLT_DETECT_EN
                        if (bus.mem_rdata == c_HLT_WORD) begin
                            r_state  <= S_HALT;
                            r_halted <= 1'b1;
                        end else begin
                            r_state       <= S_ISSUE;
                            r_instr_valid <= 1'b1;
                        end
`else
                        r_state       <= S_ISSUE;
                        r_instr_valid <= 1'b1;
`endif
                    end
                end
                S_ISSUE: begin
                    if (bus.instr_ack) begin
                        r_pc          <= r_pc + 1'b1;
                        r_fetch_count <= r_fetch_count + 16'd1;
                        r_instr_valid <= 1'b0;
                        r_mem_rd      <= 1'b1;
                        r_state       <= S_FETCH;
                    end
                end
                S_HALT: begin
`ifdef HLT_DETECT_EN
                    if (bus.pc_load) begin
                        r_pc     <= bus.pc_in;
                        r_halted <= 1'b0;
                        r_state  <= S_IDLE;
                    end
`else
                    r_state <= S_IDLE;
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.mem_addr    = r_pc;
    assign bus.mem_rd      = r_mem_rd;
    assign bus.instr_valid = r_instr_valid;
    assign bus.I           = r_ir[15];
    assign bus.opcode      = r_ir[14:12];
    assign bus.IR_address  = r_ir[11:0];
    assign bus.fetch_count = r_fetch_count;
`ifdef HLT_DETECT_EN
    assign bus.halted      = r_halted;
`else
    assign bus.halted      = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/instr_fetch_issue.md
# instr_fetch_issue

Instruction fetch and issue sequencer that feeds the basic-computer CPU its instruction fields. It holds the program counter and reads 16-bit instruction words from memory over a ready-based read handshake. Each word is split into `I` (bit 15), `opcode` (bits 14:12) and `IR_address` (bits 11:0), and the fields are held stable under a valid/ack handshake until the CPU takes them. It is the producer side of the `IR_address`/`opcode`/`I` interface the CPU consumes.

## Interface
- `AW`, 12, address / PC width; also the width of `IR_address`.
- `DW`, 16, instruction word width; the field split above is fixed to `DW`=16.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin fetching at the current PC. Sampled only in IDLE.
- `pc_load` in 1: load `pc_in` into the PC. Honoured only in IDLE or HALT.
- `pc_in` in AW: new PC value.
- `mem_addr` out AW: read address; equals PC.
- `mem_rd` out 1: read request; high throughout FETCH.
- `mem_rdata` in DW: read data; valid in any cycle with `mem_ready`=1.
- `mem_ready` in 1: read completes this cycle. Ignored when `mem_rd`=0.
- `IR_address` out AW: instruction address field.
- `opcode` out 3: instruction opcode field.
- `I` out 1: indirect bit.
- `instr_valid` out 1: the fields are valid.
- `instr_ack` in 1: the CPU consumes the fields this cycle.
- `halted` out 1: high in HALT.
- `fetch_count` out 16: number of words issued; wraps.

## Operation
- FSM states: IDLE, FETCH, ISSUE, HALT.
- IDLE:
  - `pc_load`=1 → PC←`pc_in`, state stays IDLE.
  - `start`=1 → FETCH.
  - If both are high in the same cycle, the load applies and FETCH then starts at `pc_in`.
- FETCH:
  - `mem_rd`=1, `mem_addr`=PC.
  - When `mem_ready`=1: IR←`mem_rdata` and state → ISSUE (or HALT, see Configuration).
  - Wait states are unbounded.
- ISSUE:
  - `instr_valid`=1 and the fields come from IR; the fields must not change while valid.
  - When `instr_ack`=1: PC←PC+1 (mod 2^AW, so 4095 wraps to 0), `fetch_count`+1, state → FETCH.
  - `instr_ack` outside ISSUE is ignored.
- HALT:
  - `halted`=1; no memory reads; PC holds.
  - `pc_load`=1 → PC←`pc_in` and state → IDLE.
  - `start` is ignored in HALT.
- `pc_load` in FETCH or ISSUE is ignored.
- Reset values:
  - state IDLE, PC 0, IR 0, `fetch_count` 0.
  - `mem_rd` 0, `instr_valid` 0, `halted` 0.
  - `IR_address` 0, `opcode` 0, `I` 0, `mem_addr` 0.
- Reset mid-operation aborts any pending read or issue. The next cycle is IDLE with all values at their reset values.

## Timing
- All outputs are registered or decoded from the state and registers; there is no combinational path from inputs to outputs.
- `start` high at edge n → `mem_rd`=1 from cycle n+1.
- `mem_ready` high at edge m → `instr_valid`=1 from cycle m+1.
- With zero-wait memory (`mem_ready` high in the first FETCH cycle) and an immediate ack, there are 2 cycles per instruction.
- `instr_ack` high at edge k → `instr_valid`=0 in cycle k+1, `mem_rd`=1 in cycle k+1, and `mem_addr`=PC+1.
- Back-to-back issue is not allowed: `instr_valid` drops for at least one cycle between instructions.
- `halted` rises in the cycle after the `mem_ready` that captured the HLT word.

## Configuration
- Macro: `HLT_DETECT_EN`.
- Defined:
  - A fetched word equal to 16'h7001 (register-reference HLT) goes FETCH→HALT instead of ISSUE.
  - It is not issued, and `fetch_count` and PC do not advance.
- Undefined:
  - 16'h7001 is issued like any other word.
  - HALT is unreachable and `halted` is tied to 0.

## Test plan
- Reset, `pc_load` with `pc_in`=12'h001, then `start`. Memory returns 16'h0001 with zero wait, ack immediately. → `mem_addr`=1, then `I`=0, `opcode`=3'b000, `IR_address`=12'h001 with `instr_valid` one cycle after `mem_ready`. Next fetch is at address 2.
- Word 16'hB68A with 3 wait cycles on `mem_ready`, ack delayed 4 cycles. → `mem_rd` is held for 4 cycles. Then `I`=1, `opcode`=3'b011, `IR_address`=12'h68A stay stable for 5 valid cycles. `fetch_count` increments by 1.
- PC loaded with 12'hFFF, two words fetched and acked. → second `mem_addr`=12'h000 (wrap).
- `HLT_DETECT_EN` defined, memory returns 16'h7001. → `halted`=1, `instr_valid` never rises, `mem_rd`=0. Then `pc_load` with 12'h010 → IDLE, `halted`=0. Without the macro, the same word issues with `opcode`=3'b111, `I`=0, `IR_address`=12'h001.
- `reset` asserted during ISSUE with `instr_valid`=1. → next cycle `instr_valid`=0, PC=0, `fetch_count`=0, and the state is IDLE.
- `pc_load`=1 with `pc_in`=12'h055 during FETCH. → ignored; the fetch completes at the old PC.
